bus_timer: RTL and testbench

- Programmable down-counting timer on the processor's external device bus.
- Consumes the processor's device-bus writes and reads (address, byte enables, write data, write enable) via the system bridge.
- Returns read data to the bridge.
- Drives one line of the processor's 6-bit hardware interrupt input, HWInt[2].
- Supports one-shot (mode 0) and auto-reload (mode 1) counting.

---
 rtl/timer_pkg.sv | 24 ++
 rtl/bus_timer.sv | 117 +++++++++++
 tb/tb_bus_timer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared encodings for the device-bus timer: FSM states, register word offsets,
// CTRL bit positions and counting modes.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/bus_timer.sv
// Programmable down-counting timer on the device bus: CTRL/PRESET/COUNT
// register file, a four-state counting FSM and a combinational read mux.
module bus_timer
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic [3:0]  BE,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t             r_state;
  logic               r_en;
  logic [1:0]         r_mode;
  logic               r_im;
  logic [CNT_W-1:0]   r_preset;
  logic [CNT_W-1:0]   r_count;
  logic               r_pending;

  state_t             w_stateNext;
  logic [CNT_W-1:0]   w_countNext;
  logic               w_pendSet;
  logic               w_pendClr;
  logic               w_enClr;
  logic               w_wr;
  logic               w_wrCtrl;
  logic               w_wrPreset;
  logic [31:0]        w_dout;

  // Only full-word writes are accepted; anything narrower is dropped.
  assign w_wr       = WE && (BE == 4'b1111);
  assign w_wrCtrl   = w_wr && (Addr == ADDR_CTRL);
  assign w_wrPreset = w_wr && (Addr == ADDR_PRESET);

  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_pendSet   = 1'b0;
    w_pendClr   = 1'b0;
    w_enClr     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_en) w_stateNext = LOAD;
      end
      LOAD: begin
        w_countNext = r_preset;
        w_stateNext = CNT;
      end
      CNT: begin
        if (!r_en) begin
          w_stateNext = IDLE;
        end else if (r_count > ONE) begin
          w_countNext = r_count - ONE;
        end else begin
          w_countNext = '0;
          w_pendSet   = 1'b1;
          w_stateNext = INT;
        end
      end
      INT: begin
        if (r_mode == MODE_RELOAD) w_pendClr = 1'b1;
        else                       w_enClr   = 1'b1;
        w_stateNext = IDLE;
      end
    endcase
  end

  // A CTRL write beats the one-shot Enable clear; a pending-set beats any clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_en      <= 1'b0;
      r_mode    <= MODE_ONESHOT;
      r_im      <= 1'b0;
      r_preset  <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
      if (w_wrCtrl) begin
        r_en   <= Din[CTRL_EN];
        r_mode <= Din[CTRL_MODE_MSB:CTRL_MODE_LSB];
        r_im   <= Din[CTRL_IM];
      end else if (w_enClr) begin
        r_en <= 1'b0;
      end
      if (w_wrPreset) r_preset <= Din[CNT_W-1:0];
      if (w_pendSet)
        r_pending <= 1'b1;
      else if (w_pendClr || w_wrCtrl || w_wrPreset)
        r_pending <= 1'b0;
    end
  end

  always_comb begin
    w_dout = '0;
    case (Addr)
      ADDR_CTRL:   w_dout = {28'd0, r_im, r_mode, r_en};
      ADDR_PRESET: w_dout = 32'(r_preset);
      ADDR_COUNT:  w_dout = 32'(r_count);
      default:     w_dout = '0;
    endcase
  end

  assign Dout = w_dout;
  assign IRQ  = r_im & r_pending;

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: expectations are queued as stimulus is applied
// and popped when the DUT output is sampled one nanosecond after each edge.
module tb_bus_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Addr;
  logic [3:0]  BE;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  bus_timer #(.CNT_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .BE   (BE),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    Addr = a;
    BE   = be;
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
    BE = 4'b0000;
  endtask

  task automatic pushExpect(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_underflow observed=%0h required=<queued value>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic readCheck(input string tag, input logic [1:0] a, input logic [31:0] val);
    pushExpect(tag, val);
    Addr = a;
    #1;
    checkOutput(Dout);
  endtask

  task automatic irqCheck(input string tag, input logic val);
    pushExpect(tag, {31'd0, val});
    checkOutput({31'd0, IRQ});
  endtask

  initial begin
    reset = 1'b0;
    Addr  = 2'd0;
    BE    = 4'b0000;
    WE    = 1'b0;
    Din   = 32'd0;

    // Power-up reset, then build some nonzero state and reset again.
    tick();
    tick();
    reset = 1'b1;
    tick();
    applyStimulus(2'd1, 4'b1111, 32'h1234);
    applyStimulus(2'd0, 4'b1111, 32'h9);
    tick();
    tick();
    tick();
    readCheck("pre_reset_preset", 2'd1, 32'h1234);
    reset = 1'b0;
    tick();
    tick();
    readCheck("reset_ctrl", 2'd0, 32'h0);
    readCheck("reset_preset", 2'd1, 32'h0);
    readCheck("reset_count", 2'd2, 32'h0);
    irqCheck("reset_irq", 1'b0);
    reset = 1'b1;
    tick();
    tick();
    tick();
    readCheck("idle_count", 2'd2, 32'h0);
    readCheck("idle_ctrl", 2'd0, 32'h0);
    irqCheck("idle_irq", 1'b0);

    // One-shot, N=5: COUNT 5..1 after E0+2..E0+6, IRQ after E0+7.
    applyStimulus(2'd1, 4'b1111, 32'd5);
    applyStimulus(2'd0, 4'b1111, 32'h9);
    for (int v = 5; v >= 1; v--) pushExpect("oneshot_count", 32'(v));
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      Addr = 2'd2;
      #1;
      checkOutput(Dout);
    end
    irqCheck("oneshot_irq_before", 1'b0);
    tick();
    readCheck("oneshot_count_zero", 2'd2, 32'h0);
    irqCheck("oneshot_irq_rise", 1'b1);
    tick();
    readCheck("oneshot_ctrl_after", 2'd0, 32'h8);
    irqCheck("oneshot_irq_held", 1'b1);
    tick();
    tick();
    irqCheck("oneshot_irq_sticky", 1'b1);
    applyStimulus(2'd0, 4'b1111, 32'h8);
    irqCheck("oneshot_irq_cleared", 1'b0);
    readCheck("oneshot_ctrl_im", 2'd0, 32'h8);

    // Auto-reload, N=3: one-cycle IRQ pulses every 6 cycles starting at E0+5.
    applyStimulus(2'd1, 4'b1111, 32'd3);
    applyStimulus(2'd0, 4'b1111, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      tick();
      pushExpect("reload_irq", {31'd0, (k >= 5) && (((k - 5) % 6) == 0)});
      checkOutput({31'd0, IRQ});
    end
    readCheck("reload_ctrl", 2'd0, 32'hB);
    applyStimulus(2'd0, 4'b1111, 32'h0);

    // Masked interrupt, then a partial CTRL write that must be ignored.
    applyStimulus(2'd1, 4'b1111, 32'd2);
    applyStimulus(2'd0, 4'b1111, 32'h1);
    for (int i = 0; i < 6; i++) tick();
    readCheck("mask_count", 2'd2, 32'h0);
    irqCheck("mask_irq", 1'b0);
    readCheck("mask_ctrl_done", 2'd0, 32'h0);
    applyStimulus(2'd0, 4'b0011, 32'h8);
    readCheck("mask_partial_ctrl", 2'd0, 32'h0);
    irqCheck("mask_partial_irq", 1'b0);

    // Pause at COUNT=10 (N=20), then ignored writes, then reload on re-enable.
    applyStimulus(2'd1, 4'b1111, 32'd20);
    applyStimulus(2'd0, 4'b1111, 32'h1);
    for (int i = 0; i < 11; i++) tick();
    applyStimulus(2'd0, 4'b1111, 32'h0);
    for (int i = 0; i < 5; i++) begin
      readCheck("pause_hold", 2'd2, 32'd10);
      tick();
    end
    applyStimulus(2'd2, 4'b1111, 32'h55);
    applyStimulus(2'd0, 4'b1110, 32'h1);
    applyStimulus(2'd1, 4'b1110, 32'h55);
    readCheck("ignored_count", 2'd2, 32'd10);
    readCheck("ignored_ctrl", 2'd0, 32'h0);
    readCheck("ignored_preset", 2'd1, 32'd20);
    applyStimulus(2'd0, 4'b1111, 32'h1);
    readCheck("reenable_not_yet", 2'd2, 32'd10);
    tick();
    tick();
    readCheck("reenable_load", 2'd2, 32'd20);
    applyStimulus(2'd0, 4'b1111, 32'h0);

    // Collision: CTRL write during INT keeps Enable and the timer reloads.
    applyStimulus(2'd1, 4'b1111, 32'd2);
    applyStimulus(2'd0, 4'b1111, 32'h9);
    for (int i = 0; i < 4; i++) tick();
    irqCheck("collide_int_irq", 1'b1);
    applyStimulus(2'd0, 4'b1111, 32'h9);
    readCheck("collide_ctrl", 2'd0, 32'h9);
    irqCheck("collide_irq_cleared", 1'b0);
    tick();
    tick();
    readCheck("collide_reload", 2'd2, 32'd2);
    for (int i = 0; i < 4; i++) tick();

    // PRESET=0: interrupt one CNT cycle after LOAD.
    applyStimulus(2'd1, 4'b1111, 32'd0);
    applyStimulus(2'd0, 4'b1111, 32'h9);
    tick();
    tick();
    irqCheck("zero_preset_irq_low", 1'b0);
    tick();
    irqCheck("zero_preset_irq_high", 1'b1);
    tick();
    tick();

    // Reset asserted while COUNT=3.
    applyStimulus(2'd1, 4'b1111, 32'd5);
    applyStimulus(2'd0, 4'b1111, 32'h9);
    for (int i = 0; i < 4; i++) tick();
    readCheck("midreset_pre", 2'd2, 32'd3);
    reset = 1'b0;
    tick();
    readCheck("midreset_count", 2'd2, 32'h0);
    readCheck("midreset_ctrl", 2'd0, 32'h0);
    irqCheck("midreset_irq", 1'b0);
    reset = 1'b1;
    tick();
    tick();
    tick();
    readCheck("post_reset_count", 2'd2, 32'h0);
    irqCheck("post_reset_irq", 1'b0);
    readCheck("unmapped_addr", 2'd3, 32'h0);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
